loop_stack_unit: RTL and testbench
==================================

Name: loop_stack_unit

Overview:
- Parametrised hardware loop stack for the BeeF core. It holds the return PCs of open '[' loops and implements forward bracket-skip when a loop is entered with a zero accumulator.
- Next generation of the memory-backed PC save/load path. Depth and PC width are generic, with overflow/underflow detection and a nesting-aware skip mode.
- Sits beside fetch_unit. Its top_pc feeds the pc_loaded mux input, and control_unit drives its ls_op.

Parameters:
- PC_W, 8: width of a stored program counter.
- DEPTH, 16: number of stack entries; must be ≥2.
- NEST_W, 8: width of the skip nesting counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- ls_op  in  2  ls_op_t command: LS_NOP=0, LS_PUSH=1, LS_POP=2, LS_SKIP=3.
- pc_in  in  PC_W  PC pushed on LS_PUSH (address after the '[').
- is_open  in  1  fetched instruction is '['; sampled only while skipping.
- is_close  in  1  fetched instruction is ']'; sampled only while skipping.
- top_pc  out  PC_W  top entry, combinational from storage; 0 when empty.
- empty  out  1  stack pointer == 0.
- full  out  1  stack pointer == DEPTH.
- count  out  $clog2(DEPTH+1)  current stack pointer.
- skipping  out  1  FSM in SKIP.
- skip_done  out  1  one-cycle pulse when skip ends.
- overflow  out  1  sticky error flag.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset (clock edge with reset=1):
  - sp=0, state=IDLE, nest=0.
  - overflow=0, underflow=0, skip_done=0.
  - Outputs become top_pc=0, empty=1, full=0, count=0, skipping=0.
  - Storage array is not cleared; top_pc is masked while empty.
  - Reset takes priority over every op, including mid-skip: the skip is abandoned and the stack is emptied.
- FSM states are IDLE and SKIP.
- IDLE, LS_NOP: no change.
- IDLE, LS_PUSH:
  - Not full: mem[sp]<=pc_in, sp<=sp+1. top_pc shows pc_in from the next cycle (1-cycle latency).
  - Full: no write, sp unchanged, overflow<=1.
- IDLE, LS_POP:
  - Not empty: sp<=sp-1.
  - Empty: sp stays 0, underflow<=1.
- IDLE, LS_SKIP: state<=SKIP, nest<=1. skipping=1 from the next cycle. Stack untouched.
- SKIP:
  - ls_op is ignored.
  - is_open=1 alone: nest<=nest+1. If nest is at its maximum (2^NEST_W-1), nest holds and overflow<=1.
  - is_close=1 alone, nest>1: nest<=nest-1.
  - is_close=1 alone, nest==1: nest<=0, state<=IDLE. skip_done=1 for exactly the next cycle, in which skipping=0.
  - is_open and is_close both 1: illegal; nest unchanged, no flag.
  - Neither set: hold.
- skip_done is registered and is 0 in every cycle other than the one described above.
- overflow and underflow clear only on reset. The stack keeps operating after an error.
- Lifetime limits:
  - sp never exceeds DEPTH and never wraps below 0.
  - nest never wraps.
- Loop use, per sequence:
  - '[' with acc≠0: PUSH.
  - ']' with acc≠0: jump to top_pc, no pop.
  - ']' with acc==0: POP.
  - '[' with acc==0: SKIP.

Decomposition:
- Package definitions gets:
  - typedef enum logic [1:0] ls_op_t {LS_NOP, LS_PUSH, LS_POP, LS_SKIP};
  - localparam LS_DEPTH_DEFAULT=16.
  - typedef enum logic ls_state_t {LS_IDLE, LS_SKIP_ST}.
- One sub-module, pc_lifo (PC_W, DEPTH):
  - Contains the register-array storage, sp, full/empty, masked top read, overflow/underflow generation.
  - loop_stack_unit wraps it with the skip FSM, nest counter and skip_done pulse.

Test Plan:
- Reset, then PUSH 0x10, 0x20, 0x30 -> count=3, top_pc=0x30. POP -> top_pc=0x20. POP twice -> empty=1, top_pc=0, underflow=0.
- With DEPTH=4: PUSH 5 times with pc_in=1..5 -> full=1 after the 4th push; 5th sets overflow=1, top_pc=4. POP -> top_pc=3, overflow still 1.
- Empty stack, POP -> underflow=1, count=0. Then PUSH 0x44 -> top_pc=0x44, underflow stays 1 until reset.
- Stack [0x08], SKIP, then bracket stream open, open, close, close, close (one per cycle):
  - skipping=1 throughout.
  - skip_done pulses exactly once, the cycle after the 3rd close.
  - nest ends 0, count=1, top_pc=0x08.
  - PUSH commands issued during SKIP are ignored.
- Mid-skip (nest=2, stack count=2), assert reset -> next cycle skipping=0, count=0, skip_done=0, flags 0. A following PUSH 0x7F -> top_pc=0x7F.
- In SKIP, drive is_open=is_close=1 for one cycle -> nest unchanged. Then a single close with nest=1 ends the skip with a skip_done pulse.

Source files
------------

// File: rtl/loop_stack_unit_pkg.sv
// Shared types for the BeeF hardware loop stack: command encoding, FSM states, defaults.
// Pure declarations; no timing or flow control of its own.
package loop_stack_unit_pkg;

   typedef enum logic [1:0] {
      LS_NOP  = 2'd0,
      LS_PUSH = 2'd1,
      LS_POP  = 2'd2,
      LS_SKIP = 2'd3
   } ls_op_t;

   typedef enum logic {
      LS_IDLE    = 1'b0,
      LS_SKIP_ST = 1'b1
   } ls_state_t;

   localparam int LS_DEPTH_DEFAULT  = 16;
   localparam int LS_PC_W_DEFAULT   = 8;
   localparam int LS_NEST_W_DEFAULT = 8;

endpackage

// File: rtl/loop_stack_unit_pc_lifo.sv
// PC LIFO: register-array storage, stack pointer, masked top read, sticky error flags.
// Push/pop take effect on the next edge; top_pc is combinational; never stalls, errors are flagged.
module pc_lifo #(
   parameter int PC_W  = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [PC_W-1:0]            pc_in,
   input  logic                       ovf_set,
   output logic [PC_W-1:0]            top_pc,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int AW    = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] D_MAX = CNT_W'(DEPTH);

   logic [PC_W-1:0]  mem_q [DEPTH];
   logic [CNT_W-1:0] sp_q, sp_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             wr_en;
   logic [CNT_W-1:0] top_idx;

   assign empty   = (sp_q == '0);
   assign full    = (sp_q == D_MAX);
   assign top_idx = sp_q - ONE;

   always_comb begin
      sp_d  = sp_q;
      ovf_d = ovf_q | ovf_set;
      udf_d = udf_q;
      wr_en = 1'b0;
      if (push) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            wr_en = 1'b1;
            sp_d  = sp_q + ONE;
         end
      end else if (pop) begin
         if (empty) begin
            udf_d = 1'b1;
         end else begin
            sp_d = sp_q - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   // Storage is deliberately left out of reset; the empty mask hides stale entries.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem_q[sp_q[AW-1:0]] <= pc_in;
      end
   end

   always_comb begin
      top_pc = '0;
      if (!empty) begin
         top_pc = mem_q[top_idx[AW-1:0]];
      end
   end

   assign count     = sp_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

endmodule

// File: rtl/loop_stack_unit.sv
// Loop stack for BeeF: wraps pc_lifo with the bracket-skip FSM, nest counter and skip_done pulse.
// Ops act on the next edge, skip_done is registered; commands are ignored (not stalled) while skipping.
module loop_stack_unit
   import loop_stack_unit_pkg::*;
#(
   parameter int PC_W   = LS_PC_W_DEFAULT,
   parameter int DEPTH  = LS_DEPTH_DEFAULT,
   parameter int NEST_W = LS_NEST_W_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  ls_op_t                     ls_op,
   input  logic [PC_W-1:0]            pc_in,
   input  logic                       is_open,
   input  logic                       is_close,
   output logic [PC_W-1:0]            top_pc,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       skipping,
   output logic                       skip_done,
   output logic                       overflow,
   output logic                       underflow
);

   localparam logic [NEST_W-1:0] NEST_ONE = NEST_W'(1);
   localparam logic [NEST_W-1:0] NEST_MAX = {NEST_W{1'b1}};

   ls_state_t         state_q, state_d;
   logic [NEST_W-1:0] nest_q, nest_d;
   logic              skip_done_q, skip_done_d;
   logic              nest_ovf;
   logic              lifo_push, lifo_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= LS_IDLE;
         nest_q      <= '0;
         skip_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         nest_q      <= nest_d;
         skip_done_q <= skip_done_d;
      end
   end

   // A simultaneous open+close is illegal and leaves the nest count untouched.
   always_comb begin
      state_d     = state_q;
      nest_d      = nest_q;
      skip_done_d = 1'b0;
      nest_ovf    = 1'b0;
      if (state_q == LS_IDLE) begin
         if (ls_op == LS_SKIP) begin
            state_d = LS_SKIP_ST;
            nest_d  = NEST_ONE;
         end
      end else begin
         if (is_open && !is_close) begin
            if (nest_q == NEST_MAX) begin
               nest_ovf = 1'b1;
            end else begin
               nest_d = nest_q + NEST_ONE;
            end
         end else if (is_close && !is_open) begin
            if (nest_q == NEST_ONE) begin
               nest_d      = '0;
               state_d     = LS_IDLE;
               skip_done_d = 1'b1;
            end else begin
               nest_d = nest_q - NEST_ONE;
            end
         end
      end
   end

   always_comb begin
      lifo_push = (state_q == LS_IDLE) && (ls_op == LS_PUSH);
      lifo_pop  = (state_q == LS_IDLE) && (ls_op == LS_POP);
      skipping  = (state_q == LS_SKIP_ST);
      skip_done = skip_done_q;
   end

   pc_lifo #(
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) u_pc_lifo (
      .clk       (clk),
      .reset     (reset),
      .push      (lifo_push),
      .pop       (lifo_pop),
      .pc_in     (pc_in),
      .ovf_set   (nest_ovf),
      .top_pc    (top_pc),
      .empty     (empty),
      .full      (full),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

endmodule

// File: tb/tb_loop_stack_unit.sv
// Directed bench for loop_stack_unit: a default instance (DEPTH=16) and a small one (DEPTH=4, NEST_W=2).
module tb_loop_stack_unit;
   import loop_stack_unit_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // instance A: defaults
   logic       a_rst, a_open, a_close;
   ls_op_t     a_op;
   logic [7:0] a_pc, a_top;
   logic       a_empty, a_full, a_skip, a_done, a_ovf, a_udf;
   logic [4:0] a_cnt;

   // instance B: DEPTH=4, NEST_W=2
   logic       b_rst, b_open, b_close;
   ls_op_t     b_op;
   logic [7:0] b_pc, b_top;
   logic       b_empty, b_full, b_skip, b_done, b_ovf, b_udf;
   logic [2:0] b_cnt;

   loop_stack_unit u_dut_a (
      .clk(clk), .reset(a_rst), .ls_op(a_op), .pc_in(a_pc),
      .is_open(a_open), .is_close(a_close), .top_pc(a_top),
      .empty(a_empty), .full(a_full), .count(a_cnt), .skipping(a_skip),
      .skip_done(a_done), .overflow(a_ovf), .underflow(a_udf)
   );

   loop_stack_unit #(.PC_W(8), .DEPTH(4), .NEST_W(2)) u_dut_b (
      .clk(clk), .reset(b_rst), .ls_op(b_op), .pc_in(b_pc),
      .is_open(b_open), .is_close(b_close), .top_pc(b_top),
      .empty(b_empty), .full(b_full), .count(b_cnt), .skipping(b_skip),
      .skip_done(b_done), .overflow(b_ovf), .underflow(b_udf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Inputs are driven 1 time unit after a rising edge and observed 1 unit after the next.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_cmd(input ls_op_t op, input logic [7:0] pc);
      a_op = op; a_pc = pc;
      step();
      a_op = LS_NOP;
   endtask

   task automatic b_cmd(input ls_op_t op, input logic [7:0] pc);
      b_op = op; b_pc = pc;
      step();
      b_op = LS_NOP;
   endtask

   task automatic a_brk(input logic o, input logic c);
      a_open = o; a_close = c;
      step();
      a_open = 1'b0; a_close = 1'b0;
   endtask

   task automatic b_brk(input logic o, input logic c);
      b_open = o; b_close = c;
      step();
      b_open = 1'b0; b_close = 1'b0;
   endtask

   task automatic a_reset();
      a_rst = 1'b1;
      step();
      a_rst = 1'b0;
   endtask

   initial begin
      a_rst = 1'b1; a_op = LS_NOP; a_pc = '0; a_open = 1'b0; a_close = 1'b0;
      b_rst = 1'b1; b_op = LS_NOP; b_pc = '0; b_open = 1'b0; b_close = 1'b0;
      #1;
      step();
      a_rst = 1'b0; b_rst = 1'b0;

      // reset state
      check_eq("rst_top",   a_top,   32'h0);
      check_eq("rst_empty", a_empty, 32'h1);
      check_eq("rst_full",  a_full,  32'h0);
      check_eq("rst_count", a_cnt,   32'h0);
      check_eq("rst_skip",  a_skip,  32'h0);
      check_eq("rst_done",  a_done,  32'h0);
      check_eq("rst_ovf",   a_ovf,   32'h0);
      check_eq("rst_udf",   a_udf,   32'h0);
      check_eq("rst_b_empty", b_empty, 32'h1);

      // basic push/pop
      a_cmd(LS_PUSH, 8'h10);
      check_eq("push1_top", a_top, 32'h10);
      a_cmd(LS_PUSH, 8'h20);
      a_cmd(LS_PUSH, 8'h30);
      check_eq("push3_count", a_cnt, 32'd3);
      check_eq("push3_top",   a_top, 32'h30);
      a_cmd(LS_POP, 8'h00);
      check_eq("pop1_top", a_top, 32'h20);
      a_cmd(LS_POP, 8'h00);
      a_cmd(LS_POP, 8'h00);
      check_eq("pop3_empty", a_empty, 32'h1);
      check_eq("pop3_top",   a_top,   32'h0);
      check_eq("pop3_udf",   a_udf,   32'h0);

      // DEPTH=4 fill and overflow
      for (int i = 1; i <= 4; i++) begin
         b_cmd(LS_PUSH, 8'(i));
         if (i == 3) check_eq("b_full_at3", b_full, 32'h0);
      end
      check_eq("b_full_at4",  b_full, 32'h1);
      check_eq("b_count_at4", b_cnt,  32'd4);
      b_cmd(LS_PUSH, 8'd5);
      check_eq("b_ovf",       b_ovf,  32'h1);
      check_eq("b_ovf_top",   b_top,  32'h4);
      check_eq("b_ovf_count", b_cnt,  32'd4);
      b_cmd(LS_POP, 8'h00);
      check_eq("b_pop_top",   b_top,  32'h3);
      check_eq("b_ovf_stick", b_ovf,  32'h1);
      check_eq("b_pop_full",  b_full, 32'h0);

      // underflow is sticky
      a_cmd(LS_POP, 8'h00);
      check_eq("udf_set",   a_udf, 32'h1);
      check_eq("udf_count", a_cnt, 32'd0);
      a_cmd(LS_PUSH, 8'h44);
      check_eq("udf_push_top", a_top, 32'h44);
      check_eq("udf_stick",    a_udf, 32'h1);

      // skip with nesting; pushes during the skip are ignored
      a_reset();
      check_eq("rst2_udf", a_udf, 32'h0);
      a_cmd(LS_PUSH, 8'h08);
      a_cmd(LS_SKIP, 8'h00);
      check_eq("skip_enter", a_skip, 32'h1);
      a_op = LS_PUSH; a_pc = 8'h99;
      a_open = 1'b1; step();
      check_eq("skip_o1", a_skip, 32'h1);
      step();
      check_eq("skip_o2", a_skip, 32'h1);
      a_open = 1'b0; a_close = 1'b1; step();
      check_eq("skip_c1_done", a_done, 32'h0);
      step();
      check_eq("skip_c2_skip", a_skip, 32'h1);
      check_eq("skip_c2_done", a_done, 32'h0);
      check_eq("skip_c2_cnt",  a_cnt,  32'd1);
      a_op = LS_NOP;
      step();
      a_close = 1'b0;
      check_eq("skip_end_skip", a_skip, 32'h0);
      check_eq("skip_end_done", a_done, 32'h1);
      check_eq("skip_end_cnt",  a_cnt,  32'd1);
      check_eq("skip_end_top",  a_top,  32'h08);
      step();
      check_eq("skip_done_1cyc", a_done, 32'h0);
      check_eq("skip_ovf", a_ovf, 32'h0);

      // reset abandons a skip in progress
      a_cmd(LS_PUSH, 8'h22);
      a_cmd(LS_SKIP, 8'h00);
      a_brk(1'b1, 1'b0);
      check_eq("mid_pre_skip", a_skip, 32'h1);
      check_eq("mid_pre_cnt",  a_cnt,  32'd2);
      a_reset();
      check_eq("mid_skip",  a_skip,  32'h0);
      check_eq("mid_cnt",   a_cnt,   32'd0);
      check_eq("mid_done",  a_done,  32'h0);
      check_eq("mid_ovf",   a_ovf,   32'h0);
      check_eq("mid_udf",   a_udf,   32'h0);
      check_eq("mid_empty", a_empty, 32'h1);
      a_cmd(LS_PUSH, 8'h7F);
      check_eq("mid_push_top", a_top, 32'h7F);
      check_eq("mid_push_skip", a_skip, 32'h0);

      // illegal open+close holds nest; one close then finishes
      a_cmd(LS_SKIP, 8'h00);
      a_brk(1'b1, 1'b1);
      check_eq("ill_skip", a_skip, 32'h1);
      check_eq("ill_done", a_done, 32'h0);
      check_eq("ill_ovf",  a_ovf,  32'h0);
      a_brk(1'b0, 1'b1);
      check_eq("ill_end_skip", a_skip, 32'h0);
      check_eq("ill_end_done", a_done, 32'h1);

      // nest saturation on a 2-bit counter sets overflow without wrapping
      b_rst = 1'b1; step(); b_rst = 1'b0;
      check_eq("b_rst_ovf", b_ovf, 32'h0);
      b_cmd(LS_SKIP, 8'h00);
      b_brk(1'b1, 1'b0);
      b_brk(1'b1, 1'b0);
      check_eq("sat_pre_ovf", b_ovf, 32'h0);
      b_brk(1'b1, 1'b0);
      check_eq("sat_ovf",  b_ovf,  32'h1);
      check_eq("sat_skip", b_skip, 32'h1);
      b_brk(1'b0, 1'b1);
      b_brk(1'b0, 1'b1);
      check_eq("sat_c2_skip", b_skip, 32'h1);
      b_brk(1'b0, 1'b1);
      check_eq("sat_end_skip", b_skip, 32'h0);
      check_eq("sat_end_done", b_done, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
